// File: rtl/active_list.sv
`default_nettype none
// ============================================================================
//  Module   : active_list
//  Purpose  : In-order active list (reorder buffer) for a 2-wide rename stage.
//             Records each renamed instruction (arch rd, new PR, previous PR),
//             marks completion from two execute ports and retires at most one
//             entry per cycle.  On retirement the previous PR is handed back to
//             the free list.  A branch recall truncates the tail back to a
//             checkpointed tail pointer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset            clock; synchronous active-high reset
//    i_ext_stall           rename stalled, no allocation this cycle
//    i_valid/i_uses_rd     per rename slot (slot 0 older)
//    i_arch_rd/i_new_pr/i_old_pr   per-slot entry payload
//    o_alloc_tag           AL index assigned to each slot (comb)
//    o_tail_ptr            current tail (comb) for checkpointing
//    o_al_stall            not enough free entries for the group (comb)
//    i_complete_valid/tag  two completion ports
//    i_commit_hold         downstream cannot take a retirement
//    i_if_recall/i_recalled_tail   branch recall
//    o_commit_*            registered retirement info (arch rd, new PR)
//    o_if_freed/o_freed_reg  registered release of the previous PR
// ============================================================================
module active_list #(
  parameter  int NUM_PR   = 64,
  parameter  int NUM_AR   = 32,
  parameter  int AL_DEPTH = 32,
  localparam int PRW      = $clog2(NUM_PR),
  localparam int ARW      = $clog2(NUM_AR),
  localparam int TW       = $clog2(AL_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ext_stall,
  input  logic [1:0]          i_valid,
  input  logic [1:0]          i_uses_rd,
  input  logic [1:0][ARW-1:0] i_arch_rd,
  input  logic [1:0][PRW-1:0] i_new_pr,
  input  logic [1:0][PRW-1:0] i_old_pr,
  output logic [1:0][TW-1:0]  o_alloc_tag,
  output logic [TW-1:0]       o_tail_ptr,
  output logic                o_al_stall,
  input  logic [1:0]          i_complete_valid,
  input  logic [1:0][TW-1:0]  i_complete_tag,
  input  logic                i_commit_hold,
  input  logic                i_if_recall,
  input  logic [TW-1:0]       i_recalled_tail,
  output logic                o_commit_valid,
  output logic [ARW-1:0]      o_commit_arch_rd,
  output logic [PRW-1:0]      o_commit_new_pr,
  output logic                o_if_freed,
  output logic [PRW-1:0]      o_freed_reg
);

  // Entry storage
  logic                r_uses_rd [AL_DEPTH];
  logic [ARW-1:0]      r_arch_rd [AL_DEPTH];
  logic [PRW-1:0]      r_new_pr  [AL_DEPTH];
  logic [PRW-1:0]      r_old_pr  [AL_DEPTH];
  logic [AL_DEPTH-1:0] r_done;

  // Pointers; count is one bit wider so full and empty are distinguishable
  logic [TW-1:0]       r_head;
  logic [TW-1:0]       r_tail;
  logic [TW:0]         r_count;

  // Registered retirement outputs
  logic                r_commit_valid;
  logic [ARW-1:0]      r_commit_arch_rd;
  logic [PRW-1:0]      r_commit_new_pr;
  logic                r_if_freed;
  logic [PRW-1:0]      r_freed_reg;

  logic [TW:0]         w_n;
  logic [TW:0]         w_free;
  logic                w_stall;
  logic                w_accept;
  logic                w_retire;
  logic [TW-1:0]       w_head_next;
  logic [1:0][TW-1:0]  w_tag;

  assign w_n      = (TW+1)'(i_valid[0]) + (TW+1)'(i_valid[1]);
  assign w_free   = (TW+1)'(AL_DEPTH) - r_count;
  assign w_stall  = (w_free < w_n);
  // Group is all-or-nothing; a recall cycle drops whatever rename presents.
  assign w_accept = ~i_ext_stall & ~w_stall & ~i_if_recall;

  // Slot 1 takes the slot after slot 0 only when slot 0 is occupied.
  assign w_tag[0] = r_tail;
  assign w_tag[1] = r_tail + TW'(i_valid[0]);

  assign w_retire    = (r_count != '0) & r_done[r_head] & ~i_commit_hold;
  assign w_head_next = r_head + TW'(w_retire);

  assign o_alloc_tag      = w_tag;
  assign o_tail_ptr       = r_tail;
  assign o_al_stall       = w_stall;
  assign o_commit_valid   = r_commit_valid;
  assign o_commit_arch_rd = r_commit_arch_rd;
  assign o_commit_new_pr  = r_commit_new_pr;
  assign o_if_freed       = r_if_freed;
  assign o_freed_reg      = r_freed_reg;

  // Payload needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 2; i++) begin
        if (i_valid[i]) begin
          r_uses_rd[w_tag[i]] <= i_uses_rd[i];
          r_arch_rd[w_tag[i]] <= i_arch_rd[i];
          r_new_pr[w_tag[i]]  <= i_new_pr[i];
          r_old_pr[w_tag[i]]  <= i_old_pr[i];
        end
      end
    end
  end

  // Done bits: completions set, fresh allocations clear.  The two never hit
  // the same tag in one cycle, so their relative order does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (i_complete_valid[j]) begin
          r_done[i_complete_tag[j]] <= 1'b1;
        end
      end
      if (w_accept) begin
        for (int i = 0; i < 2; i++) begin
          if (i_valid[i]) begin
            r_done[w_tag[i]] <= 1'b0;
          end
        end
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head <= w_head_next;
      if (i_if_recall) begin
        r_tail  <= i_recalled_tail;
        // Distance from the post-retire head; equal pointers mean empty.
        r_count <= {1'b0, i_recalled_tail - w_head_next};
      end else begin
        if (w_accept) begin
          r_tail <= r_tail + w_n[TW-1:0];
        end
        r_count <= r_count + (w_accept ? w_n : '0) - (TW+1)'(w_retire);
      end
    end
  end

  // Retirement outputs: flags pulse for one cycle, payload holds between.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_valid   <= 1'b0;
      r_commit_arch_rd <= '0;
      r_commit_new_pr  <= '0;
      r_if_freed       <= 1'b0;
      r_freed_reg      <= '0;
    end else if (w_retire) begin
      r_commit_valid   <= 1'b1;
      r_commit_arch_rd <= r_arch_rd[r_head];
      r_commit_new_pr  <= r_new_pr[r_head];
      r_if_freed       <= r_uses_rd[r_head];
      r_freed_reg      <= r_old_pr[r_head];
    end else begin
      r_commit_valid   <= 1'b0;
      r_if_freed       <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_active_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_active_list
//  Purpose  : Self-checking bench for active_list.  A table of per-cycle
//             stimulus/expectation records covers allocation, in-order and
//             out-of-order completion, commit hold, uses_rd=0 retirement and
//             recall coinciding with retirement; hand-written sequences cover
//             full/stall, recall reuse of a completed tag, pointer wrap and
//             reset mid-operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_active_list;

  localparam int TW  = 5;
  localparam int PRW = 6;
  localparam int ARW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                ext_stall;
  logic [1:0]          valid, uses_rd;
  logic [1:0][ARW-1:0] arch_rd;
  logic [1:0][PRW-1:0] new_pr, old_pr;
  logic [1:0][TW-1:0]  alloc_tag;
  logic [TW-1:0]       tail_ptr;
  logic                al_stall;
  logic [1:0]          complete_valid;
  logic [1:0][TW-1:0]  complete_tag;
  logic                commit_hold, if_recall;
  logic [TW-1:0]       recalled_tail;
  logic                commit_valid;
  logic [ARW-1:0]      commit_arch_rd;
  logic [PRW-1:0]      commit_new_pr;
  logic                if_freed;
  logic [PRW-1:0]      freed_reg;

  active_list dut (
    .clk              (clk),
    .reset            (reset),
    .i_ext_stall      (ext_stall),
    .i_valid          (valid),
    .i_uses_rd        (uses_rd),
    .i_arch_rd        (arch_rd),
    .i_new_pr         (new_pr),
    .i_old_pr         (old_pr),
    .o_alloc_tag      (alloc_tag),
    .o_tail_ptr       (tail_ptr),
    .o_al_stall       (al_stall),
    .i_complete_valid (complete_valid),
    .i_complete_tag   (complete_tag),
    .i_commit_hold    (commit_hold),
    .i_if_recall      (if_recall),
    .i_recalled_tail  (recalled_tail),
    .o_commit_valid   (commit_valid),
    .o_commit_arch_rd (commit_arch_rd),
    .o_commit_new_pr  (commit_new_pr),
    .o_if_freed       (if_freed),
    .o_freed_reg      (freed_reg)
  );

  typedef struct packed {
    logic       ext;
    logic [1:0] v, u;
    logic [4:0] a0, a1;
    logic [5:0] n0, n1, o0, o1;
    logic [1:0] cv;
    logic [4:0] t0, t1;
    logic       hold, rec;
    logic [4:0] rt;
  } in_t;

  typedef struct packed {
    logic [4:0] tag0, tag1, tail;
    logic       stall;
    logic [5:0] count;
    logic       cv, fr;
    logic [5:0] freg;
    logic [4:0] carch;
    logic [5:0] cnpr;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } step_t;

  step_t tbl[$];
  int    total = 0;
  int    bad   = 0;

  function automatic in_t vin(input logic ext, input logic [1:0] v, input logic [1:0] u,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [5:0] n0, input logic [5:0] n1,
                              input logic [5:0] o0, input logic [5:0] o1,
                              input logic [1:0] cv, input logic [4:0] t0, input logic [4:0] t1,
                              input logic hold, input logic rec, input logic [4:0] rt);
    in_t s;
    s.ext = ext; s.v = v; s.u = u; s.a0 = a0; s.a1 = a1;
    s.n0 = n0; s.n1 = n1; s.o0 = o0; s.o1 = o1;
    s.cv = cv; s.t0 = t0; s.t1 = t1; s.hold = hold; s.rec = rec; s.rt = rt;
    return s;
  endfunction

  function automatic exp_t vexp(input logic [4:0] tag0, input logic [4:0] tag1,
                                input logic [4:0] tail, input logic stall,
                                input logic [5:0] count, input logic cv, input logic fr,
                                input logic [5:0] freg, input logic [4:0] carch,
                                input logic [5:0] cnpr);
    exp_t e;
    e.tag0 = tag0; e.tag1 = tag1; e.tail = tail; e.stall = stall; e.count = count;
    e.cv = cv; e.fr = fr; e.freg = freg; e.carch = carch; e.cnpr = cnpr;
    return e;
  endfunction

  function automatic in_t idle();
    return vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input in_t i, input exp_t e);
    step_t s;
    s.i = i;
    s.e = e;
    tbl.push_back(s);
  endtask

  task automatic drive(input in_t s);
    ext_stall       = s.ext;
    valid           = s.v;
    uses_rd         = s.u;
    arch_rd[0]      = s.a0;
    arch_rd[1]      = s.a1;
    new_pr[0]       = s.n0;
    new_pr[1]       = s.n1;
    old_pr[0]       = s.o0;
    old_pr[1]       = s.o1;
    complete_valid  = s.cv;
    complete_tag[0] = s.t0;
    complete_tag[1] = s.t1;
    commit_hold     = s.hold;
    if_recall       = s.rec;
    recalled_tail   = s.rt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(idle());
    tick();
    tick();
    reset = 1'b0;
  endtask

  int fq[$];
  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // ---- per-cycle table ------------------------------------------------
    // two allocations, completions back to back, freed 5 then 6
    add(vin(0, 2'b11, 2'b11, 3, 4, 32, 33, 5, 6, 2'b00, 0, 0, 0, 0, 0), vexp(0, 1, 0, 0, 2, 0, 0, 0, 0, 0));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0),    vexp(2, 2, 2, 0, 2, 0, 0, 0, 0, 0));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0),    vexp(2, 2, 2, 0, 1, 1, 1, 5, 3, 32));
    add(idle(),                                                          vexp(2, 2, 2, 0, 0, 1, 1, 6, 4, 33));
    add(idle(),                                                          vexp(2, 2, 2, 0, 0, 0, 0, 6, 4, 33));
    // out-of-order completion: tag 3 first, nothing retires until tag 2
    add(vin(0, 2'b11, 2'b11, 7, 8, 40, 41, 10, 11, 2'b00, 0, 0, 0, 0, 0), vexp(2, 3, 2, 0, 2, 0, 0, 6, 4, 33));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3, 0, 0, 0),    vexp(4, 4, 4, 0, 2, 0, 0, 6, 4, 33));
    add(idle(),                                                          vexp(4, 4, 4, 0, 2, 0, 0, 6, 4, 33));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0),    vexp(4, 4, 4, 0, 2, 0, 0, 6, 4, 33));
    add(idle(),                                                          vexp(4, 4, 4, 0, 1, 1, 1, 10, 7, 40));
    add(idle(),                                                          vexp(4, 4, 4, 0, 0, 1, 1, 11, 8, 41));
    add(idle(),                                                          vexp(4, 4, 4, 0, 0, 0, 0, 11, 8, 41));
    // commit hold, uses_rd=0 retirement, recall together with retirement
    add(vin(0, 2'b11, 2'b10, 9, 10, 42, 43, 12, 13, 2'b00, 0, 0, 0, 0, 0), vexp(4, 5, 4, 0, 2, 0, 0, 11, 8, 41));
    add(vin(0, 2'b11, 2'b11, 11, 12, 44, 45, 14, 15, 2'b00, 0, 0, 0, 0, 0), vexp(6, 7, 6, 0, 4, 0, 0, 11, 8, 41));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 4, 5, 1, 0, 0),    vexp(8, 8, 8, 0, 4, 0, 0, 11, 8, 41));
    add(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0),    vexp(8, 8, 8, 0, 4, 0, 0, 11, 8, 41));
    add(idle(),                                                          vexp(8, 8, 8, 0, 3, 1, 0, 12, 9, 42));
    add(vin(0, 2'b11, 2'b11, 20, 21, 60, 61, 30, 31, 2'b00, 0, 0, 0, 1, 7), vexp(8, 9, 8, 0, 1, 1, 1, 13, 10, 43));
    add(vin(0, 2'b01, 2'b01, 1, 0, 46, 0, 16, 0, 2'b00, 0, 0, 0, 0, 0),  vexp(7, 8, 7, 0, 2, 0, 0, 13, 10, 43));
    add(vin(1, 2'b10, 2'b10, 0, 2, 0, 47, 0, 17, 2'b00, 0, 0, 0, 0, 0),  vexp(8, 8, 8, 0, 2, 0, 0, 13, 10, 43));

    // ---- reset state ----------------------------------------------------
    do_reset();
    chk("rst_count", 32'(dut.r_count), 0);
    chk("rst_tail", 32'(tail_ptr), 0);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_freed", 32'(if_freed), 0);
    chk("rst_freg", 32'(freed_reg), 0);
    chk("rst_carch", 32'(commit_arch_rd), 0);
    chk("rst_cnpr", 32'(commit_new_pr), 0);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      #1;
      chk($sformatf("s%0d_tag0", k), 32'(alloc_tag[0]), 32'(tbl[k].e.tag0));
      chk($sformatf("s%0d_tag1", k), 32'(alloc_tag[1]), 32'(tbl[k].e.tag1));
      chk($sformatf("s%0d_tail", k), 32'(tail_ptr), 32'(tbl[k].e.tail));
      chk($sformatf("s%0d_stall", k), 32'(al_stall), 32'(tbl[k].e.stall));
      tick();
      chk($sformatf("s%0d_count", k), 32'(dut.r_count), 32'(tbl[k].e.count));
      chk($sformatf("s%0d_cvalid", k), 32'(commit_valid), 32'(tbl[k].e.cv));
      chk($sformatf("s%0d_ifreed", k), 32'(if_freed), 32'(tbl[k].e.fr));
      chk($sformatf("s%0d_freg", k), 32'(freed_reg), 32'(tbl[k].e.freg));
      chk($sformatf("s%0d_carch", k), 32'(commit_arch_rd), 32'(tbl[k].e.carch));
      chk($sformatf("s%0d_cnpr", k), 32'(commit_new_pr), 32'(tbl[k].e.cnpr));
    end

    // ---- reset mid-operation: pending entries vanish, no free pulse ------
    reset = 1'b1;
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    drive(idle());
    tick();
    chk("mrst_cv", 32'(commit_valid), 0);
    chk("mrst_freed", 32'(if_freed), 0);
    chk("mrst_count", 32'(dut.r_count), 0);
    chk("mrst_tail", 32'(tail_ptr), 0);
    chk("mrst_freg", 32'(freed_reg), 0);

    // ---- full list and single-entry headroom ------------------------------
    for (int k = 0; k < 16; k++) begin
      drive(vin(0, 2'b11, 2'b11, 5'(k), 5'(k), 6'(k), 6'(k), 6'(k), 6'(k), 2'b00, 0, 0, 0, 0, 0));
      tick();
    end
    chk("full_count", 32'(dut.r_count), 32);
    chk("full_tail", 32'(tail_ptr), 0);
    drive(vin(0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("full_stall2", 32'(al_stall), 1);
    drive(vin(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("full_stall1", 32'(al_stall), 1);
    tick();
    chk("full_hold", 32'(dut.r_count), 32);
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
    tick();
    drive(idle());
    tick();
    chk("one_free_count", 32'(dut.r_count), 31);
    drive(vin(0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("one_free_stall2", 32'(al_stall), 1);
    drive(vin(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("one_free_stall1", 32'(al_stall), 0);
    chk("one_free_tag0", 32'(alloc_tag[0]), 0);
    tick();
    chk("refill_count", 32'(dut.r_count), 32);
    chk("refill_tail", 32'(tail_ptr), 1);

    // ---- recall reuses a tag that had completed ---------------------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(vin(0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      tick();
    end
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3, 0, 0, 0));
    tick();
    drive(vin(0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3));
    tick();
    chk("rec_tail", 32'(tail_ptr), 3);
    chk("rec_count", 32'(dut.r_count), 3);
    drive(vin(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("rec_tag0", 32'(alloc_tag[0]), 3);
    tick();
    chk("rec_count2", 32'(dut.r_count), 4);
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 0, 1, 0, 0, 0));
    tick();
    pulses = 0;
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0));
    tick();
    if (commit_valid) pulses++;
    drive(idle());
    for (int k = 0; k < 6; k++) begin
      tick();
      if (commit_valid) pulses++;
    end
    chk("rec_retired", 32'(pulses), 3);
    chk("rec_left", 32'(dut.r_count), 1);

    // ---- pointer wrap: head 30, tail wraps to 2 ---------------------------
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(vin(0, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 5'(2*k), 5'(2*k+1), 0, 0, 0));
      tick();
    end
    drive(idle());
    for (int c = 0; c < 64 && dut.r_count != 0; c++) tick();
    chk("wrap_drained", 32'(dut.r_count), 0);
    chk("wrap_tail30", 32'(tail_ptr), 30);
    drive(vin(0, 2'b11, 2'b11, 1, 2, 20, 21, 50, 51, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("wrap_tag30", 32'(alloc_tag[0]), 30);
    chk("wrap_tag31", 32'(alloc_tag[1]), 31);
    tick();
    drive(vin(0, 2'b11, 2'b11, 3, 4, 22, 23, 52, 53, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("wrap_tag0", 32'(alloc_tag[0]), 0);
    chk("wrap_tag1", 32'(alloc_tag[1]), 1);
    tick();
    chk("wrap_count", 32'(dut.r_count), 4);
    chk("wrap_tail2", 32'(tail_ptr), 2);
    fq.delete();
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 30, 31, 0, 0, 0));
    tick();
    if (if_freed) fq.push_back(int'(freed_reg));
    drive(vin(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 0, 1, 0, 0, 0));
    tick();
    if (if_freed) fq.push_back(int'(freed_reg));
    drive(idle());
    for (int k = 0; k < 8; k++) begin
      tick();
      if (if_freed) fq.push_back(int'(freed_reg));
    end
    chk("wrap_nfreed", 32'(fq.size()), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_freed%0d", k), (k < fq.size()) ? 32'(fq[k]) : 32'hFFFF, 32'(50 + k));
    end
    chk("wrap_head", 32'(dut.r_head), 2);
    chk("wrap_empty", 32'(dut.r_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
